game_ctrl: RTL

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/game_ctrl.sv
// game_ctrl: top-level sequencer for the chicken-crossing game.
// Synchronises the move button, generates the vertical/horizontal scroll
// pulses, tracks lives and runs the IDLE/PLAY/HIT/OVER flow.
// Optional feature macro: GAME_CTRL_PAUSE_EN adds pause_btn / paused.
module game_ctrl #(
   parameter int LIVES      = 3,
   parameter int HIT_FRAMES = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       move_btn,
   input  logic       collision,
   input  logic [7:0] score,
`ifdef GAME_CTRL_PAUSE_EN
   input  logic       pause_btn,
   output logic       paused,
`endif
   output logic       step_v,
   output logic       step_h,
   output logic       game_rst,
   output logic [1:0] state,
   output logic [1:0] lives,
   output logic       flash
);

   typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, HIT = 2'd2, OVER = 2'd3} st_t;

   st_t        st;
   logic [2:0] btn_q;
   logic       btn_edge;
   logic [3:0] period;
   logic [3:0] hcnt;
   logic [3:0] hcnt_nxt;
   logic       h_fire;
   logic [7:0] hit_cnt;
   logic [7:0] hit_cnt_nxt;
   logic       hit_flag;
   logic       v_used;
   logic       play_run;
   logic       score_unused;

   assign state        = st;
   assign score_unused = ^score[4:0];
   assign btn_edge     = btn_q[1] & ~btn_q[2];
   // Faster scroll as score grows: 8 frames at score 0 down to 1 frame.
   assign period       = 4'd8 - {1'b0, score[7:5]};
   assign hcnt_nxt     = hcnt + 4'd1;
   // >= so a score jump that shortens the period fires on the next tick.
   assign h_fire       = frame_tick && (hcnt_nxt >= period);
   assign hit_cnt_nxt  = hit_cnt + 8'd1;

   // Two-flop synchroniser plus a history flop for rising-edge detection.
   always_ff @(posedge clk) begin
      if (reset) btn_q <= 3'b000;
      else       btn_q <= {btn_q[1:0], move_btn};
   end

`ifdef GAME_CTRL_PAUSE_EN
   logic [2:0] pause_q;
   logic       pause_edge;
   assign pause_edge = pause_q[1] & ~pause_q[2];
   assign play_run   = !paused && !pause_edge;

   // Pause button synchroniser and PLAY-only pause toggle.
   always_ff @(posedge clk) begin
      if (reset) begin
         pause_q <= 3'b000;
         paused  <= 1'b0;
      end else begin
         pause_q <= {pause_q[1:0], pause_btn};
         if (st == PLAY && pause_edge) paused <= ~paused;
      end
   end
`else
   assign play_run = 1'b1;
`endif

   // Game state machine; all outputs are registered here.
   always_ff @(posedge clk) begin
      if (reset) begin
         st       <= IDLE;
         lives    <= 2'(LIVES);
         step_v   <= 1'b0;
         step_h   <= 1'b0;
         game_rst <= 1'b0;
         flash    <= 1'b0;
         hcnt     <= 4'd0;
         hit_cnt  <= 8'd0;
         hit_flag <= 1'b0;
         v_used   <= 1'b0;
      end else begin
         step_v   <= 1'b0;
         step_h   <= 1'b0;
         game_rst <= 1'b0;
         case (st)
            IDLE: begin
               // The starting press only starts the game; it never steps.
               if (btn_edge) begin
                  st       <= PLAY;
                  lives    <= 2'(LIVES);
                  game_rst <= 1'b1;
                  hcnt     <= 4'd0;
                  hit_flag <= 1'b0;
                  v_used   <= 1'b0;
               end
            end
            PLAY: begin
               if (play_run) begin
                  if (frame_tick && (hit_flag || collision)) begin
                     // Hit wins over any coincident step request.
                     st       <= HIT;
                     lives    <= (lives == 2'd0) ? 2'd0 : lives - 2'd1;
                     flash    <= 1'b1;
                     hit_cnt  <= 8'd0;
                     hit_flag <= 1'b0;
                  end else begin
                     if (frame_tick) begin
                        hit_flag <= 1'b0;
                        v_used   <= 1'b0;
                        if (h_fire) begin
                           step_h <= 1'b1;
                           hcnt   <= 4'd0;
                        end else begin
                           hcnt <= hcnt_nxt;
                        end
                     end else if (collision) begin
                        hit_flag <= 1'b1;
                     end
                     // One vertical step per frame; extra presses are dropped.
                     // A press colliding with a step_h tick is also dropped so
                     // the two scroll pulses never overlap.
                     if (btn_edge && !v_used && !h_fire) begin
                        step_v <= 1'b1;
                        v_used <= 1'b1;
                     end
                  end
               end
            end
            HIT: begin
               if (frame_tick) begin
                  if (hit_cnt_nxt == 8'(HIT_FRAMES)) begin
                     flash    <= 1'b0;
                     hcnt     <= 4'd0;
                     v_used   <= 1'b0;
                     hit_flag <= 1'b0;
                     if (lives == 2'd0) begin
                        st <= OVER;
                     end else begin
                        st       <= PLAY;
                        game_rst <= 1'b1;
                     end
                  end else begin
                     hit_cnt <= hit_cnt_nxt;
                     if (hit_cnt_nxt[2:0] == 3'd0) flash <= ~flash;
                  end
               end
            end
            OVER: begin
               if (btn_edge) st <= IDLE;
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule
